// File: rtl/vga_draw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_draw_arbiter_if
// Desc     : Drawer request/stream bus plus shared VGA write port.
// Revision : 1.0  initial release
// ============================================================================
interface vga_draw_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  drw_done;
    logic [31:0] drw_x;
    logic [27:0] drw_y;
    logic [35:0] drw_colour;
    logic [3:0]  drw_resetn;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [8:0]  vga_colour;
    logic        vga_plot;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  draw_done;
    logic        timeout_err;

    modport slave (
        input  req, drw_done, drw_x, drw_y, drw_colour,
        output drw_resetn, vga_x, vga_y, vga_colour, vga_plot,
               grant, busy, draw_done, timeout_err
    );

    modport master (
        output req, drw_done, drw_x, drw_y, drw_colour,
        input  drw_resetn, vga_x, vga_y, vga_colour, vga_plot,
               grant, busy, draw_done, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_draw_arbiter
// Desc     : Grants the VGA write port to one of four self-sequencing drawers.
// Options  : ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
// Revision : 1.0  initial release
// ============================================================================
module vga_draw_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PRIME_CYCLES = 2,
    parameter int TIMEOUT      = 20000
) (
    input  logic              clk,
    input  logic              resetn,
    vga_draw_arbiter_if.slave bus
);
    localparam int PR_W = $clog2(PRIME_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_PRIME   = 3'd2,
        S_DRAW    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   pending_q;
    logic [NUM_REQ-1:0]   pending_d;
    logic [1:0]           owner_q;
    logic [1:0]           owner_d;
    logic [NUM_REQ-1:0]   owner_mask;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   drw_resetn_q;
    logic [NUM_REQ-1:0]   draw_done_q;
    logic                 busy_q;
    logic                 timeout_err_q;
    logic [PR_W-1:0]      prime_cnt_q;
    logic [TO_W-1:0]      timeout_cnt_q;
    logic [7:0]           x_hold_q;
    logic [6:0]           y_hold_q;
    logic [8:0]           colour_hold_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0]           last_q;
`endif

    logic [7:0] x_arr      [NUM_REQ];
    logic [6:0] y_arr      [NUM_REQ];
    logic [8:0] colour_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign x_arr[g]      = bus.drw_x[8*g +: 8];
        assign y_arr[g]      = bus.drw_y[7*g +: 7];
        assign colour_arr[g] = bus.drw_colour[9*g +: 9];
    end

    logic       in_draw;
    logic       owner_done;
    logic [7:0] mux_x;
    logic [6:0] mux_y;
    logic [8:0] mux_colour;

    assign in_draw    = (state_q == S_DRAW);
    assign owner_done = bus.drw_done[owner_q];
    assign mux_x      = x_arr[owner_q];
    assign mux_y      = y_arr[owner_q];
    assign mux_colour = colour_arr[owner_q];
    assign owner_mask = NUM_REQ'(1) << owner_q;

    // Selection scans from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        owner_d = 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pending_q[last_q + 2'(k) + 2'd1]) begin
                owner_d = last_q + 2'(k) + 2'd1;
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                owner_d = 2'(i);
            end
        end
`endif
    end

    // A request landing on the release cycle survives the clear, so the drawer is redrawn.
    always_comb begin
        pending_d = pending_q | bus.req;
        if (state_q == S_RELEASE) begin
            pending_d = (pending_q & ~owner_mask) | bus.req;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            owner_q       <= 2'd0;
            grant_q       <= '0;
            drw_resetn_q  <= '0;
            draw_done_q   <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            prime_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            x_hold_q      <= '0;
            y_hold_q      <= '0;
            colour_hold_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q        <= 2'd3;
`endif
        end else begin
            pending_q   <= pending_d;
            draw_done_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (|pending_q) begin
                        owner_q <= owner_d;
                        grant_q <= NUM_REQ'(1) << owner_d;
                        busy_q  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q  <= owner_d;
`endif
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    prime_cnt_q   <= '0;
                    timeout_cnt_q <= '0;
                    drw_resetn_q  <= grant_q;
                    state_q       <= S_PRIME;
                end
                S_PRIME: begin
                    if (prime_cnt_q == PR_W'(PRIME_CYCLES - 1)) begin
                        state_q <= S_DRAW;
                    end else begin
                        prime_cnt_q <= prime_cnt_q + PR_W'(1);
                    end
                end
                S_DRAW: begin
                    x_hold_q      <= mux_x;
                    y_hold_q      <= mux_y;
                    colour_hold_q <= mux_colour;
                    if (owner_done || (timeout_cnt_q == TO_W'(TIMEOUT - 1))) begin
                        if (!owner_done) begin
                            timeout_err_q <= 1'b1;
                        end
                        grant_q      <= '0;
                        drw_resetn_q <= '0;
                        draw_done_q  <= owner_mask;
                        state_q      <= S_RELEASE;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + TO_W'(1);
                    end
                end
                S_RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.drw_resetn  = drw_resetn_q;
    assign bus.draw_done   = draw_done_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.vga_plot    = in_draw && !owner_done;
    assign bus.vga_x       = in_draw ? mux_x      : x_hold_q;
    assign bus.vga_y       = in_draw ? mux_y      : y_hold_q;
    assign bus.vga_colour  = in_draw ? mux_colour : colour_hold_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_draw_arbiter
// Desc     : Scoreboard bench with drawer models and transaction-level reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_draw_arbiter;
    localparam int P      = 2;
    localparam int TO     = 20000;
    localparam int MAXERR = 50;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    vga_draw_arbiter_if bus();

    vga_draw_arbiter #(.NUM_REQ(4), .PRIME_CYCLES(P), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // One expected draw: edges at which START, DRAW and RELEASE begin.
    typedef struct {
        int drw;
        int st;
        int db;
        int dlen;
        int plots;
        int rel;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   e      = 0;
    int   len  [4];
    int   dcnt [4];
    logic [3:0] glitch    = '0;
    logic [3:0] noise     = '0;
    logic       noise_en  = 1'b0;
    logic       fixed_pix = 1'b0;

    logic [3:0] m_pend     = '0;
    int         m_free     = 0;
    int         m_clr      = -1;
    int         m_clr_drw  = 0;
    int         m_terr_edg = -1;
    int         m_last     = 3;
    logic       m_terr     = 1'b0;
    logic       m_in_reset = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%h expected=%h", name, e, act, exp);
            if (errors >= MAXERR) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    endtask

    // Drawer models: count while released, raise done after PRIME + len cycles.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            dcnt[i] <= bus.drw_resetn[i] ? dcnt[i] + 1 : 0;
        end
    end

    always_comb begin
        bus.drw_done = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.drw_resetn[i]) begin
                bus.drw_done[i] = (dcnt[i] < P && glitch[i]) || (dcnt[i] >= P + len[i]);
            end else begin
                bus.drw_done[i] = noise[i] & noise_en;
            end
        end
    end

    initial begin
        bus.drw_x      = '0;
        bus.drw_y      = '0;
        bus.drw_colour = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.drw_x      = $urandom;
            bus.drw_y      = 28'($urandom);
            bus.drw_colour = 36'({$urandom, $urandom});
            noise          = 4'($urandom);
            if (fixed_pix) begin
                bus.drw_x[15:8]       = 8'd159;
                bus.drw_y[13:7]       = 7'd119;
                bus.drw_colour[17:9]  = 9'h1FF;
            end
        end
    end

    // Reference: decide owner from pending set, then schedule the whole draw arithmetically.
    initial begin
        forever begin
            int   s;
            int   dl;
            exp_t it;
            @(posedge clk);
            e++;
            if (!resetn) begin
                m_pend     = '0;
                m_free     = 0;
                m_clr      = -1;
                m_terr     = 1'b0;
                m_terr_edg = -1;
                m_last     = 3;
                m_in_reset = 1'b1;
                q.delete();
            end else begin
                m_in_reset = 1'b0;
                if (e == m_terr_edg) m_terr = 1'b1;
                if (e >= m_free && m_pend != 0) begin
                    s = -1;
`ifdef ARB_ROUND_ROBIN_EN
                    for (int k = 1; k <= 4; k++) begin
                        if (s < 0 && m_pend[(m_last + k) % 4]) s = (m_last + k) % 4;
                    end
`else
                    for (int j = 0; j < 4; j++) begin
                        if (s < 0 && m_pend[j]) s = j;
                    end
`endif
                    dl       = (len[s] >= TO) ? TO : len[s] + 1;
                    it.drw   = s;
                    it.st    = e;
                    it.db    = e + 1 + P;
                    it.dlen  = dl;
                    it.plots = (len[s] >= TO) ? TO : len[s];
                    it.rel   = e + 1 + P + dl;
                    q.push_back(it);
                    m_clr     = it.rel + 1;
                    m_clr_drw = s;
                    m_free    = m_clr + 1;
                    m_last    = s;
                    if (len[s] >= TO) m_terr_edg = it.rel;
                end
                if (e == m_clr) m_pend[m_clr_drw] = 1'b0;
                m_pend = m_pend | bus.req;
            end
        end
    end

    // Monitor: compare every cycle against the front transaction, retire it on draw_done.
    initial begin
        logic [23:0] last_pix;
        logic [23:0] exp_pix;
        logic [14:0] exp_ctrl;
        logic [3:0]  oh;
        logic        have;
        logic        in_draw;
        exp_t        it;
        last_pix = '0;
        forever begin
            @(negedge clk);
            if (m_in_reset) last_pix = '0;
            have = (q.size() > 0);
            if (have) it = q[0];
            oh = have ? (4'b0001 << it.drw) : 4'b0000;
            in_draw = have && e >= it.db && e < it.db + it.dlen;
            exp_ctrl = {
                (have && e >= it.st && e < it.rel) ? oh : 4'b0000,
                (have && e > it.st && e < it.rel) ? oh : 4'b0000,
                have && e >= it.st && e <= it.rel,
                (have && e == it.rel) ? oh : 4'b0000,
                have && e >= it.db && e < it.db + it.plots,
                m_terr
            };
            chk("ctrl{grant,drw_resetn,busy,draw_done,plot,terr}",
                32'({bus.grant, bus.drw_resetn, bus.busy, bus.draw_done, bus.vga_plot, bus.timeout_err}),
                32'(exp_ctrl));
            if (in_draw) begin
                exp_pix  = {bus.drw_x[8*it.drw +: 8], bus.drw_y[7*it.drw +: 7], bus.drw_colour[9*it.drw +: 9]};
                last_pix = exp_pix;
                chk("pixel_mux", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(exp_pix));
            end else begin
                chk("pixel_hold", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(last_pix));
            end
            if (have && e == it.rel) void'(q.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        bus.req = m;
        step(1);
        bus.req = '0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((q.size() != 0 || m_pend != 0) && k < budget) begin
            step(1);
            k++;
        end
        chk("wait_idle_in_budget", 32'(k < budget), 32'd1);
    endtask

    task automatic wait_q(input int budget);
        int k;
        k = 0;
        while (q.size() == 0 && k < budget) begin
            step(1);
            k++;
        end
        chk("wait_grant_in_budget", 32'(k < budget), 32'd1);
    endtask

    initial begin
        int target;
        int n;
        bus.req = '0;
        for (int i = 0; i < 4; i++) len[i] = 10;
        step(3);
        resetn = 1'b1;
        step(2);

        len[2] = 19200;
        pulse(4'b0100);
        wait_idle(21000);

        len[1] = 40; len[3] = 25; glitch = 4'b1010; noise_en = 1'b1;
        pulse(4'b1010);
        wait_idle(600);

        len[0] = 20;
        pulse(4'b0001);
        wait_q(50);
        target = (q.size() > 0) ? q[0].rel : e;
        for (int k = 0; k < 500 && e < target; k++) step(1);
        pulse(4'b0001);
        wait_idle(600);

        fixed_pix = 1'b1; len[1] = 60;
        pulse(4'b0010);
        wait_idle(600);
        fixed_pix = 1'b0;

        len[3] = 30000; len[0] = 15; glitch = 4'b0000;
        pulse(4'b1000);
        step(50);
        pulse(4'b0001);
        wait_idle(21000);

        len[1] = 3000;
        pulse(4'b0010);
        step(3);
        pulse(4'b0100);
        wait_q(50);
        target = (q.size() > 0) ? q[0].db + 500 : e;
        for (int k = 0; k < 1000 && e < target; k++) step(1);
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        step(20);
        len[2] = 5;
        pulse(4'b0100);
        wait_idle(200);

        for (int rd = 0; rd < 25; rd++) begin
            for (int i = 0; i < 4; i++) len[i] = $urandom_range(0, 80);
            glitch   = 4'($urandom);
            noise_en = 1'($urandom);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                pulse(4'($urandom));
                step($urandom_range(0, 40));
            end
            wait_idle(3000);
        end

        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
